// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode encoding and the memory-stage controller state.
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2,
      DONE   = 2'd3
   } mem_ctrl_state_t;

   function automatic logic is_indirect(input lc3b_opcode op);
      return (op == op_ldi) || (op == op_sti);
   endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for the data port: store replication, lane enables,
// and load byte extraction with sign extension.
module mem_byte_align (
   input  logic        byte_op_i,
   input  logic        addr_lsb_i,
   input  logic [15:0] wdata_i,
   input  logic [15:0] rdata_i,
   output logic [15:0] wdata_o,
   output logic [1:0]  wr_be_o,
   output logic [15:0] rdata_o
);

   logic [7:0] sel_byte;

   always_comb begin
      sel_byte = addr_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
      if (byte_op_i) begin
         wdata_o = {wdata_i[7:0], wdata_i[7:0]};
         wr_be_o = addr_lsb_i ? 2'b10 : 2'b01;
         rdata_o = {{8{sel_byte[7]}}, sel_byte};
      end else begin
         wdata_o = wdata_i;
         wr_be_o = 2'b11;
         rdata_o = rdata_i;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: direct loads/stores plus two-access
// indirect LDI/STI, stalling the front of the pipe until the access completes.
module mem_stage_ctrl
   import lc3b_types::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  lc3b_opcode      opcode,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            byte_op,
   input  logic [15:0]     addr,
   input  logic [15:0]     wdata,
   input  logic            dmem_resp,
   input  logic [15:0]     dmem_rdata,
   output logic            dmem_read,
   output logic            dmem_write,
   output logic [15:0]     dmem_address,
   output logic [15:0]     dmem_wdata,
   output logic [1:0]      dmem_byte_enable,
   output logic            stall,
   output logic [15:0]     rdata_out,
   output logic            done,
   output mem_ctrl_state_t state_dbg
);

   mem_ctrl_state_t state_q, state_d;
   lc3b_opcode      opcode_q, opcode_d;
   logic            byte_op_q, byte_op_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
   logic            indirect_q, indirect_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic [15:1]     ptr_q, ptr_d;
   logic [15:0]     rdata_q, rdata_d;

   logic            accept;
   logic            lane_byte;
   logic [1:0]      lane_be;
   logic [15:0]     load_val;

   // Held in reset, a qualifying packet must not raise stall.
   assign accept    = valid_in & (mem_read | mem_write) & ~reset;
   // Only the first access of a direct byte op uses a sub-word lane.
   assign lane_byte = byte_op_q & (state_q == FIRST);

   mem_byte_align u_align (
      .byte_op_i  (lane_byte),
      .addr_lsb_i (addr_q[0]),
      .wdata_i    (wdata_q),
      .rdata_i    (dmem_rdata),
      .wdata_o    (dmem_wdata),
      .wr_be_o    (lane_be),
      .rdata_o    (load_val)
   );

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      byte_op_d    = byte_op_q;
      read_d       = read_q;
      write_d      = write_q;
      indirect_d   = indirect_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ptr_d        = ptr_q;
      rdata_d      = rdata_q;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      dmem_address = 16'h0000;
      stall        = 1'b0;
      done         = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               opcode_d   = opcode;
               byte_op_d  = byte_op;
               read_d     = mem_read;
               write_d    = mem_write;
               addr_d     = addr;
               wdata_d    = wdata;
               indirect_d = is_indirect(opcode);
               stall      = 1'b1;
               state_d    = FIRST;
            end
         end
         FIRST: begin
            stall        = 1'b1;
            dmem_address = byte_op_q ? addr_q : {addr_q[15:1], 1'b0};
            if (indirect_q) begin
               // Pointer fetch: strobe drops in the response cycle.
               if (dmem_resp) begin
                  ptr_d   = dmem_rdata[15:1];
                  state_d = SECOND;
               end else begin
                  dmem_read = 1'b1;
               end
            end else begin
               dmem_read  = read_q;
               dmem_write = write_q & ~read_q;
               if (dmem_resp) begin
                  if (read_q) rdata_d = load_val;
                  state_d = DONE;
               end
            end
         end
         SECOND: begin
            stall        = 1'b1;
            dmem_address = {ptr_q, 1'b0};
            dmem_read    = (opcode_q == op_ldi);
            dmem_write   = (opcode_q == op_sti);
            if (dmem_resp) begin
               if (opcode_q == op_ldi) rdata_d = load_val;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dmem_byte_enable = dmem_write ? lane_be : 2'b00;
   assign rdata_out        = rdata_q;
   assign state_dbg        = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         opcode_q   <= op_br;
         byte_op_q  <= 1'b0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         indirect_q <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 16'h0000;
         ptr_q      <= 15'h0000;
         rdata_q    <= 16'h0000;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         byte_op_q  <= byte_op_d;
         read_q     <= read_d;
         write_q    <= write_d;
         indirect_q <= indirect_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ptr_q      <= ptr_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed plus randomized bench for mem_stage_ctrl with a transaction-level
// memory model and expected-value computation.
module tb_mem_stage_ctrl;
   import lc3b_types::*;

   logic            clk;
   logic            reset;
   logic            valid_in;
   lc3b_opcode      opcode;
   logic            mem_read, mem_write, byte_op;
   logic [15:0]     addr, wdata;
   logic            dmem_resp;
   logic [15:0]     dmem_rdata;
   logic            dmem_read, dmem_write;
   logic [15:0]     dmem_address, dmem_wdata;
   logic [1:0]      dmem_byte_enable;
   logic            stall;
   logic [15:0]     rdata_out;
   logic            done;
   mem_ctrl_state_t state_dbg;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_rdata = 16'h0000;

   mem_stage_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .opcode           (opcode),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .byte_op          (byte_op),
      .addr             (addr),
      .wdata            (wdata),
      .dmem_resp        (dmem_resp),
      .dmem_rdata       (dmem_rdata),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_address     (dmem_address),
      .dmem_wdata       (dmem_wdata),
      .dmem_byte_enable (dmem_byte_enable),
      .stall            (stall),
      .rdata_out        (rdata_out),
      .done             (done),
      .state_dbg        (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Scramble packet inputs while an access is in flight; they must be ignored.
   task automatic scramble_packet();
      valid_in  = 1'($urandom);
      opcode    = lc3b_opcode'(4'($urandom));
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      byte_op   = 1'($urandom);
      addr      = 16'($urandom);
      wdata     = 16'($urandom);
   endtask

   // Byte load from the reference memory word: pick lane, sign-extend.
   function automatic logic [15:0] ref_byte_load(input logic [15:0] word, input logic odd);
      int b;
      b = odd ? (int'(word) / 256) : (int'(word) % 256);
      return (b >= 128) ? 16'(b + 32'hFF00) : 16'(b);
   endfunction

   // One full packet from IDLE through the post-DONE IDLE cycle. Entered and left at a negedge.
   task automatic do_txn(input lc3b_opcode op, input logic rd, input logic wr, input logic bop,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] r1, input logic [15:0] r2,
                         input int lat1, input int lat2, input string name);
      logic        ind;
      logic [15:0] exp_a1, exp_a2, exp_wd, exp_rdata;
      logic [1:0]  exp_be;
      int          stall_cnt, rd_hs, wr_hs, exp_rd_hs, exp_wr_hs;
      logic        e_rd1, e_wr1;

      ind    = (op == op_ldi) || (op == op_sti);
      exp_a1 = bop ? a : 16'((a / 2) * 2);
      exp_a2 = 16'((r1 / 2) * 2);
      e_rd1  = ind || rd;
      e_wr1  = !ind && wr;
      exp_wd = bop ? 16'((wd % 256) * 257) : wd;
      exp_be = !bop ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
      if (op == op_ldi)  exp_rdata = r2;
      else if (rd)       exp_rdata = bop ? ref_byte_load(r1, a[0]) : r1;
      else               exp_rdata = last_rdata;
      exp_rd_hs = int'(e_rd1) + int'(op == op_ldi);
      exp_wr_hs = int'(e_wr1) + int'(op == op_sti);
      stall_cnt = 0; rd_hs = 0; wr_hs = 0;

      valid_in = 1'b1; opcode = op; mem_read = rd; mem_write = wr; byte_op = bop;
      addr = a; wdata = wd; dmem_resp = 1'b0;
      #1;
      check({name, " accept_stall"}, 32'(stall), 32'd1);
      check({name, " accept_no_strobe"}, 32'({dmem_read, dmem_write}), 32'd0);
      stall_cnt += int'(stall);
      next_cycle();

      for (int k = 0; k < lat1; k++) begin
         dmem_resp = 1'b0;
         scramble_packet();
         dmem_rdata = 16'($urandom);
         #1;
         check({name, " p1_read"}, 32'(dmem_read), 32'(e_rd1));
         check({name, " p1_write"}, 32'(dmem_write), 32'(e_wr1));
         check({name, " p1_addr"}, 32'(dmem_address), 32'(exp_a1));
         if (e_wr1) begin
            check({name, " p1_wdata"}, 32'(dmem_wdata), 32'(exp_wd));
            check({name, " p1_be"}, 32'(dmem_byte_enable), 32'(exp_be));
         end
         stall_cnt += int'(stall);
         if (k == lat1 - 1) begin
            rd_hs += int'(dmem_read);
            wr_hs += int'(dmem_write);
            dmem_resp  = 1'b1;
            dmem_rdata = r1;
            #1;
            if (ind) check({name, " p1_resp_drop"}, 32'({dmem_read, dmem_write}), 32'd0);
         end
         next_cycle();
      end

      if (ind) begin
         for (int k = 0; k < lat2; k++) begin
            dmem_resp = 1'b0;
            scramble_packet();
            dmem_rdata = 16'($urandom);
            #1;
            check({name, " p2_read"}, 32'(dmem_read), 32'(op == op_ldi));
            check({name, " p2_write"}, 32'(dmem_write), 32'(op == op_sti));
            check({name, " p2_addr"}, 32'(dmem_address), 32'(exp_a2));
            if (op == op_sti) begin
               check({name, " p2_wdata"}, 32'(dmem_wdata), 32'(wd));
               check({name, " p2_be"}, 32'(dmem_byte_enable), 32'd3);
            end
            stall_cnt += int'(stall);
            if (k == lat2 - 1) begin
               rd_hs += int'(dmem_read);
               wr_hs += int'(dmem_write);
               dmem_resp  = 1'b1;
               dmem_rdata = r2;
            end
            next_cycle();
         end
      end

      // DONE cycle, with a spurious response that must be ignored.
      valid_in  = 1'b0;
      dmem_resp = 1'($urandom);
      #1;
      check({name, " done_pulse"}, 32'(done), 32'd1);
      check({name, " done_stall"}, 32'(stall), 32'd0);
      check({name, " done_strobes"}, 32'({dmem_read, dmem_write}), 32'd0);
      check({name, " done_state"}, 32'(state_dbg), 32'(DONE));
      check({name, " rdata"}, 32'(rdata_out), 32'(exp_rdata));
      check({name, " stall_cycles"}, 32'(stall_cnt), 32'(1 + lat1 + (ind ? lat2 : 0)));
      check({name, " read_handshakes"}, 32'(rd_hs), 32'(exp_rd_hs));
      check({name, " write_handshakes"}, 32'(wr_hs), 32'(exp_wr_hs));
      next_cycle();
      dmem_resp = 1'b0;
      #1;
      check({name, " post_done"}, 32'(done), 32'd0);
      check({name, " post_state"}, 32'(state_dbg), 32'(IDLE));
      check({name, " rdata_hold"}, 32'(rdata_out), 32'(exp_rdata));
      last_rdata = exp_rdata;
      @(negedge clk);
   endtask

   initial begin
      lc3b_opcode  ops[6];
      lc3b_opcode  op;
      logic [15:0] ptr;
      ops = '{op_ldr, op_ldb, op_str, op_stb, op_ldi, op_sti};

      reset = 1'b1; valid_in = 1'b0; opcode = op_br; mem_read = 1'b0; mem_write = 1'b0;
      byte_op = 1'b0; addr = 16'h0; wdata = 16'h0; dmem_resp = 1'b0; dmem_rdata = 16'h0;
      repeat (2) @(negedge clk);
      valid_in = 1'b1; mem_read = 1'b1;
      #1;
      check("reset_state", 32'(state_dbg), 32'(IDLE));
      check("reset_strobes", 32'({dmem_read, dmem_write}), 32'd0);
      check("reset_stall", 32'(stall), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_rdata", 32'(rdata_out), 32'd0);
      check("reset_be", 32'(dmem_byte_enable), 32'd0);
      valid_in = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      do_txn(op_ldr, 1, 0, 0, 16'h3001, 16'h0000, 16'hBEEF, 16'h0000, 3, 1, "ldr");
      do_txn(op_ldb, 1, 0, 1, 16'h4003, 16'h0000, 16'h80AA, 16'h0000, 2, 1, "ldb_hi");
      do_txn(op_ldb, 1, 0, 1, 16'h4002, 16'h0000, 16'h80AA, 16'h0000, 1, 1, "ldb_lo");
      do_txn(op_stb, 0, 1, 1, 16'h5001, 16'h1234, 16'h0000, 16'h0000, 2, 1, "stb");
      do_txn(op_ldi, 1, 0, 0, 16'h6000, 16'h0000, 16'h7001, 16'h0042, 2, 3, "ldi");

      // Non-memory packet, plus a stray response while idle.
      valid_in = 1'b1; opcode = op_add; mem_read = 1'b0; mem_write = 1'b0;
      dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
      #1;
      check("add_stall", 32'(stall), 32'd0);
      check("add_strobes", 32'({dmem_read, dmem_write}), 32'd0);
      next_cycle();
      #1;
      check("add_state", 32'(state_dbg), 32'(IDLE));
      check("add_done", 32'(done), 32'd0);
      check("add_rdata", 32'(rdata_out), 32'(last_rdata));
      valid_in = 1'b0; dmem_resp = 1'b0;
      @(negedge clk);

      // STI aborted by reset during the second access.
      ptr = 16'h2222;
      valid_in = 1'b1; opcode = op_sti; mem_read = 1'b0; mem_write = 1'b1; byte_op = 1'b0;
      addr = 16'h1110; wdata = 16'hCAFE;
      next_cycle();
      valid_in = 1'b0; dmem_resp = 1'b1; dmem_rdata = ptr;
      next_cycle();
      dmem_resp = 1'b0;
      #1;
      check("sti_second_state", 32'(state_dbg), 32'(SECOND));
      check("sti_second_write", 32'(dmem_write), 32'd1);
      check("sti_second_addr", 32'(dmem_address), 32'(ptr));
      reset = 1'b1;
      #1;
      check("abort_strobes", 32'({dmem_read, dmem_write}), 32'd0);
      check("abort_state", 32'(state_dbg), 32'(IDLE));
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_be", 32'(dmem_byte_enable), 32'd0);
      check("abort_rdata", 32'(rdata_out), 32'd0);
      last_rdata = 16'h0000;
      next_cycle();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_no_write", 32'(dmem_write), 32'd0);
      end

      for (int n = 0; n < 30; n++) begin
         logic rd, bop;
         op  = ops[$urandom_range(0, 5)];
         rd  = (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
         bop = (op == op_ldb) || (op == op_stb);
         do_txn(op, rd, !rd, bop, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 4), $urandom_range(1, 4), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
